// File: rtl/nx_fifo_rd_stream.sv
// Read-side streamer for nx_fifo: pops words into a 2-entry buffer and presents them on valid/ready.
// Optional transfer counter enabled by defining NX_FIFO_RD_STREAM_STATS_EN.
module nx_fifo_rd_stream #(
  parameter int WIDTH     = 611,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_ren,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 drain,
  output logic                 drain_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       occ;
  logic             head, tail;
  logic [WIDTH-1:0] mem [2];
  logic             push, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (drain) state_n = DRAIN;
      DRAIN:   if (fifo_empty) state_n = DONE;
      DONE:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Read decision looks at registered occ only, so out_ready never reaches fifo_ren.
  always_comb begin
    out_valid  = 1'b0;
    fifo_ren   = 1'b0;
    drain_done = 1'b0;
    case (state)
      RUN: begin
        out_valid = (occ != 2'd0);
        fifo_ren  = !fifo_empty && (occ != 2'd2);
      end
      DRAIN:   fifo_ren   = !fifo_empty;
      DONE:    drain_done = 1'b1;
      default: ;
    endcase
    if (rst) fifo_ren = 1'b0;
  end

  assign busy     = (occ != 2'd0) || (state != RUN);
  assign push     = fifo_ren && (state == RUN);
  assign pop      = out_valid && out_ready;
  assign out_data = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (state == RUN && drain) begin
      // Entering drain discards the buffer; a same-cycle FIFO pop is dropped too.
      occ  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= fifo_rdata;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef NX_FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
  end
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Bench for nx_fifo_rd_stream: behavioural FIFO in front, scoreboard queue behind.
module tb_nx_fifo_rd_stream;
  localparam int W  = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_ren;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          drain;
  logic          drain_done;
  logic          busy;
  logic [CW-1:0] xfer_cnt;

  always #5 clk = ~clk;

  nx_fifo_rd_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_ren(fifo_ren), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .drain(drain), .drain_done(drain_done),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int total = 0, bad = 0;
  int cyc_n = 0;
  int ren_cnt, dd_cnt, dd_cyc, first_ren, first_ov, first_acc, last_acc, acc_cnt;
  int acc_since_rst = 0;
  int n0, pushed;
  logic p_ov = 1'b0, p_rdy = 1'b0, p_drn = 1'b0;
  logic [W-1:0] p_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xexp();
`ifdef NX_FIFO_RD_STREAM_STATS_EN
    return 64'(acc_since_rst);
`else
    return 64'd0;
`endif
  endfunction

  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_w(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    upd_fifo();
  endtask

  task automatic clr_stats();
    ren_cnt = 0; dd_cnt = 0; dd_cyc = -1; first_ren = -1; first_ov = -1;
    first_acc = -1; last_acc = -1; acc_cnt = 0;
  endtask

  // One clock: sample mid-cycle, then advance past the rising edge and update the FIFO model.
  task automatic cyc();
    logic ren;
    #1;
    ren = fifo_ren;
    chk("ren_while_empty", {63'd0, fifo_ren & fifo_empty}, 64'd0);
    if (p_ov && !p_rdy && !p_drn) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", 64'(out_data), 64'(p_data));
    end
    if (fifo_ren) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc_n;
    end
    if (out_valid && first_ov < 0) first_ov = cyc_n;
    if (drain_done) begin
      dd_cnt++;
      dd_cyc = cyc_n;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_has_entry", 64'(exp_q.size()), 64'd1);
      else chk("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
      acc_cnt++;
      acc_since_rst++;
      if (first_acc < 0) first_acc = cyc_n;
      last_acc = cyc_n;
    end
    p_ov = out_valid; p_rdy = out_ready; p_drn = drain; p_data = out_data;
    @(posedge clk);
    #1;
    if (ren && fq.size() != 0) void'(fq.pop_front());
    cyc_n++;
    upd_fifo();
  endtask

  initial begin
    rst = 1'b1; drain = 1'b0; out_ready = 1'b0;
    upd_fifo();
    clr_stats();
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_fifo_ren", {63'd0, fifo_ren}, 64'd0);
    chk("rst_drain_done", {63'd0, drain_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // streaming with out_ready held high
    clr_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_w(32'hA0 + i);
    n0 = cyc_n;
    repeat (8) cyc();
    chk("t1_first_ren", 64'(first_ren), 64'(n0));
    chk("t1_first_ov", 64'(first_ov), 64'(n0 + 1));
    chk("t1_acc", 64'(acc_cnt), 64'd4);
    chk("t1_consecutive", 64'(last_acc - first_acc), 64'd3);
    chk("t1_xfer_cnt", 64'(xfer_cnt), xexp());

    // back-pressure
    clr_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_w(32'hB0 + i);
    repeat (6) cyc();
    chk("t2_ren_cnt", 64'(ren_cnt), 64'd2);
    chk("t2_fifo_left", 64'(fq.size()), 64'd2);
    chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_out_data", 64'(out_data), 64'h0B0);
    chk("t2_busy", {63'd0, busy}, 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
    chk("t2_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t2_acc", 64'(acc_cnt), 64'd4);
    repeat (2) cyc();

    // drain with a full buffer and 3 words left in the FIFO
    clr_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_w(32'hC0 + i);
    repeat (4) cyc();
    chk("t3_fifo_pre", 64'(fq.size()), 64'd3);
    chk("t3_ov_pre", {63'd0, out_valid}, 64'd1);
    clr_stats();
    n0 = cyc_n;
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    chk("t3_ov_drop", {63'd0, out_valid}, 64'd0);
    repeat (8) cyc();
    chk("t3_ren_cnt", 64'(ren_cnt), 64'd3);
    chk("t3_dd_cnt", 64'(dd_cnt), 64'd1);
    chk("t3_dd_cyc", 64'(dd_cyc), 64'(n0 + 5));
    chk("t3_busy", {63'd0, busy}, 64'd0);
    chk("t3_fifo_empty", 64'(fq.size()), 64'd0);
    chk("t3_acc", 64'(acc_cnt), 64'd0);
    exp_q.delete();

    // drain with nothing anywhere
    clr_stats();
    n0 = cyc_n;
    drain = 1'b1;
    cyc();
    drain = 1'b0;
    repeat (5) cyc();
    chk("t4_dd_cyc", 64'(dd_cyc), 64'(n0 + 2));
    chk("t4_dd_cnt", 64'(dd_cnt), 64'd1);
    chk("t4_ren_cnt", 64'(ren_cnt), 64'd0);

    // asynchronous reset mid-operation
    clr_stats();
    out_ready = 1'b0;
    push_w(32'hD0);
    repeat (2) cyc();
    chk("t5_ov_pre", {63'd0, out_valid}, 64'd1);
    chk("t5_data_pre", 64'(out_data), 64'h0D0);
    push_w(32'hD1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ov", {63'd0, out_valid}, 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    chk("t5_rst_ren", {63'd0, fifo_ren}, 64'd0);
    chk("t5_rst_dd", {63'd0, drain_done}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_xfer", 64'(xfer_cnt), 64'd0);
    void'(exp_q.pop_front());
    acc_since_rst = 0;
    p_ov = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clr_stats();
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) cyc();
    chk("t5_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t5_acc", 64'(acc_cnt), 64'd1);
    chk("t5_xfer", 64'(xfer_cnt), xexp());

    // random back-pressure over 1000 words
    clr_stats();
    pushed = 0;
    for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() != 0); c++) begin
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push_w(32'h1000_0000 + pushed);
        pushed++;
      end
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("t6_acc", 64'(acc_cnt), 64'd1000);
    chk("t6_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t6_xfer", 64'(xfer_cnt), xexp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
